argmax_sequencer: RTL and testbench
===================================

Name: argmax_sequencer

Overview:
- Sequences one comparator2 instance over a stream of NUM_VALUES signed samples and produces the maximum value and its index.
- Sits between a sample producer, such as a classifier output layer, and a result consumer.
- Uses valid/ready handshakes on both sides.
- Supports one frame at a time, started by a start pulse.

Parameters:
DATA_WIDTH, 16, sample width in bits; samples are two's complement.
BITS_FOR_POSITION, 4, index width in bits.
NUM_VALUES, 10, samples per frame; legal range 2..2**BITS_FOR_POSITION; violation is an elaboration-time error.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; honoured only in IDLE.
abort  in  1  synchronous abort; returns to IDLE from any state.
in_valid  in  1  sample valid.
in_data  in  DATA_WIDTH  sample, signed.
in_ready  out  1  block accepts a sample this cycle.
busy  out  1  high in COLLECT or RESULT.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_pos  out  BITS_FOR_POSITION  index of the maximum (0-based, arrival order).
out_value  out  DATA_WIDTH  maximum sample.

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE; idx, max_reg and pos_reg are 0; in_ready=0, out_valid=0, busy=0, out_pos=0, out_value=0.
- States: IDLE, COLLECT, RESULT. All outputs are registered or decoded from state only; no input-to-output combinational path except as stated below.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and abort=0 -> COLLECT, idx<=0.
- COLLECT:
  - in_ready=1.
  - A sample is accepted when in_valid and in_ready are both high.
  - Accept with idx==0: max_reg<=in_data, pos_reg<=0.
  - Accept with idx>0: comparator2 has a=in_data, pos_a=idx, b=max_reg, pos_b=pos_reg. max_reg<=value_max, pos_reg<=pos_max.
  - Ties: the comparator uses a strict signed greater-than, so on a tie the earlier index is kept.
  - Each accept increments idx. An accept at idx==NUM_VALUES-1 -> RESULT, with the final update applied in the same edge.
  - in_valid=0: no state change; gaps of any length are allowed.
- RESULT:
  - out_valid=1; out_pos=pos_reg and out_value=max_reg, held stable until the handshake.
  - out_valid and out_ready both high -> IDLE, out_valid<=0.
  - Latency: out_valid rises on the cycle after the last sample is accepted.
- start outside IDLE is ignored and does not queue.
- abort=1 in any state -> IDLE next edge; idx cleared, out_valid<=0; partial result discarded.
- abort and start in the same cycle in IDLE: abort wins and the block stays in IDLE.
- Reset asserted mid-frame: immediate return to reset values; no result is produced.
- No back-to-back frames without passing through IDLE; minimum one idle cycle between frames.
- idx width is BITS_FOR_POSITION. It never wraps because the frame terminates at NUM_VALUES-1.

Decomposition:
- Shared package argmax_pkg holds:
  - state enum (IDLE=2'd0, COLLECT=2'd1, RESULT=2'd2);
  - the NUM_VALUES range-check function.
- Sub-module: exactly one comparator2 instance (u_cmp), with DATA_WIDTH and BITS_FOR_POSITION passed through.
- FSM, counter and registers live in argmax_sequencer itself.

Test Plan:
1. NUM_VALUES=4; start, then samples 3, -7, 12, 5 back-to-back with out_ready=1 -> out_valid one cycle after the 4th accept, out_pos=2, out_value=12, then IDLE.
2. NUM_VALUES=4; all-negative samples -9, -2, -2, -30 -> out_pos=1, out_value=-2 (tie keeps the earlier index; signed compare, not unsigned).
3. NUM_VALUES=4; samples 1, 9, 4, 2 with in_valid gaps of 0–3 random cycles and out_ready held low 5 cycles -> result held stable 5 cycles at out_pos=1, out_value=9; start pulses during COLLECT and RESULT are ignored.
4. Abort after the 2nd sample, then a new frame 0, 0, 0, 8 -> no out_valid for the aborted frame; new result out_pos=3, out_value=8.
5. rst_n pulsed low for 1 cycle asynchronously mid-COLLECT -> all outputs 0 immediately; busy=0; next frame 16'h7FFF, 16'h8000, 0, 1 -> out_pos=0, out_value=32767.
6. Default parameters (NUM_VALUES=10), samples 0..9 ascending -> out_pos=9, out_value=9; idx does not wrap; busy deasserts after the output handshake.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types and elaboration helpers for the argmax sequencer slice.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // A frame needs at least two samples and its last index must fit the position field.
  function automatic bit num_values_ok(input int unsigned num_values,
                                       input int unsigned bits_for_position);
    return (num_values >= 2) && (num_values <= (32'd1 << bits_for_position));
  endfunction

endpackage

// File: rtl/argmax_sequencer_if.sv
// Control, sample-in and result-out bundle for argmax_sequencer.
interface argmax_sequencer_if #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned BITS_FOR_POSITION = 4
);
  logic                         start;
  logic                         abort;
  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_ready;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [BITS_FOR_POSITION-1:0] out_pos;
  logic [DATA_WIDTH-1:0]        out_value;

  modport master (
    output start, abort, in_valid, in_data, out_ready,
    input  in_ready, busy, out_valid, out_pos, out_value
  );

  modport slave (
    input  start, abort, in_valid, in_data, out_ready,
    output in_ready, busy, out_valid, out_pos, out_value
  );
endinterface

// File: rtl/argmax_sequencer_comparator2.sv
// Two-input signed max selector; strict greater-than so a tie keeps operand b.
module comparator2 #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned BITS_FOR_POSITION = 4
) (
  input  logic signed [DATA_WIDTH-1:0]        a,
  input  logic        [BITS_FOR_POSITION-1:0] pos_a,
  input  logic signed [DATA_WIDTH-1:0]        b,
  input  logic        [BITS_FOR_POSITION-1:0] pos_b,
  output logic signed [DATA_WIDTH-1:0]        value_max,
  output logic        [BITS_FOR_POSITION-1:0] pos_max
);
  logic a_gt_b;

  always_comb begin
    a_gt_b    = (a > b);
    value_max = a_gt_b ? a : b;
    pos_max   = a_gt_b ? pos_a : pos_b;
  end
endmodule

// File: rtl/argmax_sequencer.sv
// Streams NUM_VALUES signed samples through one comparator and reports max value and index.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned BITS_FOR_POSITION = 4,
  parameter int unsigned NUM_VALUES        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  argmax_sequencer_if.slave  bus
);

  if (!num_values_ok(NUM_VALUES, BITS_FOR_POSITION)) begin : g_bad_num_values
    $error("argmax_sequencer: NUM_VALUES out of range 2..2**BITS_FOR_POSITION");
  end

  localparam logic [BITS_FOR_POSITION-1:0] LAST_IDX = BITS_FOR_POSITION'(NUM_VALUES - 1);

  state_t                              state_q, state_d;
  logic        [BITS_FOR_POSITION-1:0] idx_q;
  logic signed [DATA_WIDTH-1:0]        max_q;
  logic        [BITS_FOR_POSITION-1:0] pos_q;
  logic signed [DATA_WIDTH-1:0]        cmp_value;
  logic        [BITS_FOR_POSITION-1:0] cmp_pos;
  logic                                accept;
  logic                                last;

  comparator2 #(
    .DATA_WIDTH        (DATA_WIDTH),
    .BITS_FOR_POSITION (BITS_FOR_POSITION)
  ) u_cmp (
    .a         ($signed(bus.in_data)),
    .pos_a     (idx_q),
    .b         (max_q),
    .pos_b     (pos_q),
    .value_max (cmp_value),
    .pos_max   (cmp_pos)
  );

  always_comb begin
    accept  = (state_q == COLLECT) && bus.in_valid;
    last    = (idx_q == LAST_IDX);
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)      state_d = COLLECT;
      COLLECT: if (accept && last) state_d = RESULT;
      RESULT:  if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // idx returns to zero on the final accept so it never has to hold NUM_VALUES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      max_q <= '0;
      pos_q <= '0;
    end else if (bus.abort) begin
      idx_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= last ? '0 : idx_q + BITS_FOR_POSITION'(1);
      if (idx_q == '0) begin
        max_q <= $signed(bus.in_data);
        pos_q <= '0;
      end else begin
        max_q <= cmp_value;
        pos_q <= cmp_pos;
      end
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == RESULT);
  assign bus.out_pos   = pos_q;
  assign bus.out_value = max_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop on each output handshake.
module tb_argmax_sequencer;

  typedef struct {
    logic [3:0]  pos;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t q4[$];
  exp_t q10[$];

  always #5 clk = ~clk;

  argmax_sequencer_if #(.DATA_WIDTH(16), .BITS_FOR_POSITION(4)) b4 ();
  argmax_sequencer_if #(.DATA_WIDTH(16), .BITS_FOR_POSITION(4)) b10 ();

  argmax_sequencer #(.DATA_WIDTH(16), .BITS_FOR_POSITION(4), .NUM_VALUES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  argmax_sequencer #(.DATA_WIDTH(16), .BITS_FOR_POSITION(4), .NUM_VALUES(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .bus(b10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [3:0] pos, input logic [15:0] val);
    exp_t e;
    e.pos = pos;
    e.val = val;
    q4.push_back(e);
  endtask

  task automatic send(input bit big, input logic [15:0] v, input int gap);
    bit acc;
    int n;
    if (big) b10.in_valid = 1'b0; else b4.in_valid = 1'b0;
    repeat (gap) tick();
    if (big) begin b10.in_valid = 1'b1; b10.in_data = v; end
    else     begin b4.in_valid  = 1'b1; b4.in_data  = v; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = big ? b10.in_ready : b4.in_ready;
      tick();
      n++;
    end
    if (big) b10.in_valid = 1'b0; else b4.in_valid = 1'b0;
    chk(big ? "accept10" : "accept4", {31'd0, acc}, 32'd1);
  endtask

  task automatic start4();
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        total_cnt++;
        $display("FAIL res4_unexpected: got pos %0d value %0h with no result expected",
                 b4.out_pos, b4.out_value);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("res4_pos", {28'd0, b4.out_pos}, {28'd0, e.pos});
        chk("res4_value", {16'd0, b4.out_value}, {16'd0, e.val});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b10.out_valid && b10.out_ready) begin
      if (q10.size() == 0) begin
        total_cnt++;
        $display("FAIL res10_unexpected: got pos %0d value %0h with no result expected",
                 b10.out_pos, b10.out_value);
      end else begin
        exp_t e;
        e = q10.pop_front();
        chk("res10_pos", {28'd0, b10.out_pos}, {28'd0, e.pos});
        chk("res10_value", {16'd0, b10.out_value}, {16'd0, e.val});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    b4.start = 0; b4.abort = 0; b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 0;
    b10.start = 0; b10.abort = 0; b10.in_valid = 0; b10.in_data = '0; b10.out_ready = 0;

    tick();
    tick();
    chk("rst_in_ready", {31'd0, b4.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, b4.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, b4.busy}, 32'd0);
    chk("rst_out_pos", {28'd0, b4.out_pos}, 32'd0);
    chk("rst_out_value", {16'd0, b4.out_value}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: mixed signs back-to-back
    b4.out_ready = 1'b1;
    push4(4'd2, 16'd12);
    start4();
    chk("t1_busy", {31'd0, b4.busy}, 32'd1);
    send(1'b0, 16'd3, 0);
    send(1'b0, -16'sd7, 0);
    send(1'b0, 16'd12, 0);
    send(1'b0, 16'd5, 0);
    chk("t1_latency", {31'd0, b4.out_valid}, 32'd1);
    tick();
    chk("t1_idle", {31'd0, b4.busy}, 32'd0);

    // Test 2: all negative with a tie
    push4(4'd1, -16'sd2);
    start4();
    send(1'b0, -16'sd9, 0);
    send(1'b0, -16'sd2, 0);
    send(1'b0, -16'sd2, 0);
    send(1'b0, -16'sd30, 0);
    tick();
    chk("t2_idle", {31'd0, b4.busy}, 32'd0);

    // Test 3: gaps, held result, ignored starts
    b4.out_ready = 1'b0;
    push4(4'd1, 16'd9);
    start4();
    send(1'b0, 16'd1, $urandom_range(0, 3));
    send(1'b0, 16'd9, $urandom_range(0, 3));
    start4();
    send(1'b0, 16'd4, $urandom_range(0, 3));
    send(1'b0, 16'd2, $urandom_range(0, 3));
    for (int c = 0; c < 5; c++) begin
      b4.start = (c == 2);
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, b4.out_valid}, 32'd1);
      chk("t3_hold_pos", {28'd0, b4.out_pos}, 32'd1);
      chk("t3_hold_value", {16'd0, b4.out_value}, 32'd9);
      tick();
    end
    b4.start = 1'b0;
    b4.out_ready = 1'b1;
    tick();
    chk("t3_idle", {31'd0, b4.busy}, 32'd0);
    tick();
    chk("t3_no_queued_start", {31'd0, b4.busy}, 32'd0);

    // Test 4: abort mid-frame, abort beats start, then a clean frame
    start4();
    send(1'b0, 16'd50, 0);
    send(1'b0, 16'd60, 0);
    b4.abort = 1'b1;
    tick();
    b4.abort = 1'b0;
    chk("t4_abort_busy", {31'd0, b4.busy}, 32'd0);
    chk("t4_abort_valid", {31'd0, b4.out_valid}, 32'd0);
    b4.abort = 1'b1;
    b4.start = 1'b1;
    tick();
    b4.abort = 1'b0;
    b4.start = 1'b0;
    chk("t4_abort_wins", {31'd0, b4.busy}, 32'd0);
    push4(4'd3, 16'd8);
    start4();
    send(1'b0, 16'd0, 0);
    send(1'b0, 16'd0, 0);
    send(1'b0, 16'd0, 0);
    send(1'b0, 16'd8, 0);
    tick();
    chk("t4_idle", {31'd0, b4.busy}, 32'd0);

    // Test 5: asynchronous reset mid-collect
    start4();
    send(1'b0, 16'd4, 0);
    send(1'b0, 16'd100, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", {31'd0, b4.in_ready}, 32'd0);
    chk("t5_rst_busy", {31'd0, b4.busy}, 32'd0);
    chk("t5_rst_out_valid", {31'd0, b4.out_valid}, 32'd0);
    chk("t5_rst_out_pos", {28'd0, b4.out_pos}, 32'd0);
    chk("t5_rst_out_value", {16'd0, b4.out_value}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push4(4'd0, 16'h7FFF);
    start4();
    send(1'b0, 16'h7FFF, 0);
    send(1'b0, 16'h8000, 0);
    send(1'b0, 16'h0000, 0);
    send(1'b0, 16'h0001, 0);
    tick();
    chk("t5_idle", {31'd0, b4.busy}, 32'd0);

    // Test 6: default-size frame, ascending
    b10.out_ready = 1'b1;
    e.pos = 4'd9;
    e.val = 16'd9;
    q10.push_back(e);
    b10.start = 1'b1;
    tick();
    b10.start = 1'b0;
    for (int i = 0; i < 10; i++) send(1'b1, 16'(i), 0);
    chk("t6_latency", {31'd0, b10.out_valid}, 32'd1);
    tick();
    chk("t6_idle", {31'd0, b10.busy}, 32'd0);
    chk("t6_in_ready", {31'd0, b10.in_ready}, 32'd0);

    tick();
    chk("q4_drained", q4.size(), 32'd0);
    chk("q10_drained", q10.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
